eth_rx_frame_buffer: RTL and testbench

ETH_RX_FRAME_BUFFER -- requirements
Module: eth_rx_frame_buffer

---
 rtl/eth_rx_frame_buffer_if.sv | 17 +
 rtl/eth_rx_frame_buffer.sv | 167 ++++++++++++++++
 tb/tb_eth_rx_frame_buffer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_buffer_if.sv
// AXI-Stream style bundle shared by the MAC-side input and the committed-frame output.
// The input side has no backpressure, so the buffer ties its tready high.
interface eth_rx_frame_buffer_if #(
  parameter int DATA_WIDTH = 64
);
  localparam int KEEP_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_W-1:0]     tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward Ethernet RX frame buffer: frames become visible on the output
// only after a clean tlast; bad-FCS and overflowing frames are rolled back.
module eth_rx_frame_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  eth_rx_frame_buffer_if.slave    s_axis,
  eth_rx_frame_buffer_if.master   m_axis,
  output logic                    rx_fifo_overflow,
  output logic [CNT_WIDTH-1:0]    drop_bad_count,
  output logic [CNT_WIDTH-1:0]    drop_ovf_count,
  output logic [$clog2(DEPTH):0]  frames_pending,
  output logic [$clog2(DEPTH):0]  words_used
);
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int MEM_W  = DATA_WIDTH + KEEP_W + 1;

  typedef enum logic [1:0] {SYNC, IDLE, WRITE, DROP} wr_state_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [MEM_W-1:0] mem [DEPTH];

  wr_state_e             state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  bad_cnt_q, bad_cnt_d;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [PW-1:0]         pend_q, pend_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [KEEP_W-1:0]     out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;

  logic             full;
  logic             mem_we;
  logic             commit;
  logic             rd_fire;
  logic             load;
  logic [MEM_W-1:0] rd_word;

  // Space check deliberately ignores a read happening in the same cycle.
  assign full    = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign rd_word = mem[rd_ptr_q[AW-1:0]];
  assign rd_fire = out_vld_q && m_axis.tready;
  assign load    = (rd_ptr_q != commit_ptr_q) && (!out_vld_q || m_axis.tready);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    ovf_d        = 1'b0;
    bad_cnt_d    = bad_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;
    mem_we       = 1'b0;
    commit       = 1'b0;
    unique case (state_q)
      SYNC: if (!s_axis.tvalid) state_d = IDLE;
      IDLE, WRITE: begin
        if (s_axis.tvalid) begin
          if (full) begin
            wr_ptr_d  = commit_ptr_q;
            ovf_d     = 1'b1;
            ovf_cnt_d = sat_inc(ovf_cnt_q);
            state_d   = s_axis.tlast ? IDLE : DROP;
          end else begin
            mem_we = 1'b1;
            if (!s_axis.tlast) begin
              wr_ptr_d = wr_ptr_q + PW'(1);
              state_d  = WRITE;
            end else if (s_axis.tuser) begin
              wr_ptr_d  = commit_ptr_q;
              bad_cnt_d = sat_inc(bad_cnt_q);
              state_d   = IDLE;
            end else begin
              wr_ptr_d     = wr_ptr_q + PW'(1);
              commit_ptr_d = wr_ptr_q + PW'(1);
              commit       = 1'b1;
              state_d      = IDLE;
            end
          end
        end
      end
      DROP: if (s_axis.tvalid && s_axis.tlast) state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end

  // Output register refills from committed storage whenever it is empty or draining.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    if (load) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      out_vld_d  = 1'b1;
      out_data_d = rd_word[DATA_WIDTH-1:0];
      out_keep_d = rd_word[DATA_WIDTH +: KEEP_W];
      out_last_d = rd_word[MEM_W-1];
    end else if (rd_fire) begin
      out_vld_d = 1'b0;
    end
    pend_d = pend_q;
    unique case ({commit, rd_fire && out_last_q})
      2'b10:   pend_d = pend_q + PW'(1);
      2'b01:   pend_d = pend_q - PW'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= SYNC;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      bad_cnt_q    <= '0;
      ovf_cnt_q    <= '0;
      pend_q       <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
      bad_cnt_q    <= bad_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      pend_q       <= pend_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  assign s_axis.tready    = 1'b1;
  assign m_axis.tdata     = out_data_q;
  assign m_axis.tkeep     = out_keep_q;
  assign m_axis.tvalid    = out_vld_q;
  assign m_axis.tlast     = out_last_q;
  assign m_axis.tuser     = 1'b0;
  assign rx_fifo_overflow = ovf_q;
  assign drop_bad_count   = bad_cnt_q;
  assign drop_ovf_count   = ovf_cnt_q;
  assign frames_pending   = pend_q;
  assign words_used       = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Directed bench for eth_rx_frame_buffer with a small depth and narrow counters so
// overflow, oversize-frame and saturation corners are reachable in a short run.
module tb_eth_rx_frame_buffer;
  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int CW    = 2;
  localparam int PW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          ovf;
  logic [CW-1:0] bad_cnt, ovf_cnt;
  logic [PW-1:0] pend, used;

  eth_rx_frame_buffer_if #(.DATA_WIDTH(DW)) s_if ();
  eth_rx_frame_buffer_if #(.DATA_WIDTH(DW)) m_if ();

  eth_rx_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .rx_fifo_overflow (ovf),
    .drop_bad_count   (bad_cnt),
    .drop_ovf_count   (ovf_cnt),
    .frames_pending   (pend),
    .words_used       (used)
  );

  always #5 aclk = ~aclk;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    ovf_pulses = 0;
  bit    stall_mode = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int id, input int idx);
    return {id[15:0], idx[15:0], ~id[15:0], ~idx[15:0]};
  endfunction

  // Output monitor: scoreboard order, keep/last, and hold-under-stall.
  always @(negedge aclk) begin
    beat_t e;
    if (ovf === 1'b1) ovf_pulses++;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", m_if.tdata, prev.d);
        chk("hold_ctl", 64'({m_if.tvalid, m_if.tkeep, m_if.tlast}), 64'({1'b1, prev.k, prev.l}));
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_if.tvalid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_if.tdata, e.d);
          chk("out_keep", 64'(m_if.tkeep), 64'(e.k));
          chk("out_last", 64'(m_if.tlast), 64'(e.l));
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev       = '{m_if.tdata, m_if.tkeep, m_if.tlast};
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
    cyc++;
    if (stall_mode) m_if.tready = (cyc % 3 != 0);
  endtask

  task automatic send_frame(input int id, input int len, input bit bad, input bit push,
                            input logic [KW-1:0] lk);
    logic [KW-1:0] k;
    for (int i = 0; i < len; i++) begin
      k = (i == len - 1) ? lk : '1;
      if (push) exp_q.push_back('{mk(id, i), k, (i == len - 1)});
      s_if.tvalid = 1'b1;
      s_if.tdata  = mk(id, i);
      s_if.tkeep  = k;
      s_if.tlast  = (i == len - 1);
      s_if.tuser  = bad && (i == len - 1);
      step();
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_q.size() == 0 && m_if.tvalid === 1'b0 && pend === '0) done = 1'b1;
      else step();
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;
    aresetn     = 1'b0;
    repeat (3) step();

    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tdata", m_if.tdata, 64'd0);
    chk("rst_tkeep", 64'(m_if.tkeep), 64'd0);
    chk("rst_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_pending", 64'(pend), 64'd0);
    chk("rst_used", 64'(used), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_bad_cnt", 64'(bad_cnt), 64'd0);
    chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    aresetn = 1'b1;
    step();
    step();

    // Good 8-beat frame: nothing visible until commit, first beat two cycles after tlast.
    send_frame(1, 8, 1'b0, 1'b1, 8'h3F);
    chk("t1_no_early_valid", 64'(m_if.tvalid), 64'd0);
    chk("t1_pending", 64'(pend), 64'd1);
    chk("t1_used", 64'(used), 64'd8);
    step();
    chk("t1_valid_latency", 64'(m_if.tvalid), 64'd1);
    wait_drain("t1_drain");
    chk("t1_used_end", 64'(used), 64'd0);

    // Bad-FCS frame rolls back, following good frame passes.
    send_frame(2, 5, 1'b1, 1'b0, 8'hFF);
    chk("t2_rollback_used", 64'(used), 64'd0);
    chk("t2_bad_cnt", 64'(bad_cnt), 64'd1);
    chk("t2_pending", 64'(pend), 64'd0);
    send_frame(3, 3, 1'b0, 1'b1, 8'h07);
    wait_drain("t2_drain");
    chk("t2_used_end", 64'(used), 64'd0);

    // Stalled output: second 10-beat frame overflows.
    m_if.tready = 1'b0;
    send_frame(4, 10, 1'b0, 1'b1, 8'hFF);
    send_frame(5, 10, 1'b0, 1'b0, 8'hFF);
    step();
    step();
    chk("t3_ovf_pulses", 64'(ovf_pulses), 64'd1);
    chk("t3_ovf_cnt", 64'(ovf_cnt), 64'd1);
    chk("t3_pending", 64'(pend), 64'd1);
    chk("t3_head_valid", 64'(m_if.tvalid), 64'd1);
    chk("t3_head_data", m_if.tdata, mk(4, 0));
    m_if.tready = 1'b1;
    wait_drain("t3_drain");

    // Oversize frame dropped; exactly-DEPTH frame fits.
    send_frame(6, 17, 1'b0, 1'b0, 8'hFF);
    chk("t4_ovf_cnt", 64'(ovf_cnt), 64'd2);
    chk("t4_used", 64'(used), 64'd0);
    chk("t4_pending0", 64'(pend), 64'd0);
    send_frame(7, 16, 1'b0, 1'b1, 8'h80);
    chk("t4_pending1", 64'(pend), 64'd1);
    wait_drain("t4_drain");
    chk("t4_ovf_pulses", 64'(ovf_pulses), 64'd2);

    // Reset on beat 4 of 8; remaining beats must be ignored.
    for (int i = 0; i < 8; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = mk(8, i);
      s_if.tkeep  = '1;
      s_if.tlast  = (i == 7);
      s_if.tuser  = 1'b0;
      if (i == 3) aresetn = 1'b0;
      step();
      aresetn = 1'b1;
      if (i == 3) begin
        chk("t5_rst_used", 64'(used), 64'd0);
        chk("t5_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("t5_rst_bad_cnt", 64'(bad_cnt), 64'd0);
        chk("t5_rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    chk("t5_sync_used", 64'(used), 64'd0);
    repeat (3) step();
    chk("t5_sync_pending", 64'(pend), 64'd0);
    chk("t5_sync_tvalid", 64'(m_if.tvalid), 64'd0);
    send_frame(9, 4, 1'b0, 1'b1, 8'h1F);
    wait_drain("t5_drain");

    // Patterned backpressure with short, single-beat and back-to-back frames.
    stall_mode = 1'b1;
    send_frame(10, 1, 1'b0, 1'b1, 8'h01);
    send_frame(11, 1, 1'b1, 1'b0, 8'hFF);
    send_frame(12, 5, 1'b0, 1'b1, 8'h0F);
    send_frame(13, 2, 1'b0, 1'b1, 8'hC3);
    wait_drain("t6_drain_a");
    send_frame(14, 12, 1'b0, 1'b1, 8'h7F);
    wait_drain("t6_drain_b");
    chk("t6_bad_cnt", 64'(bad_cnt), 64'd1);
    stall_mode  = 1'b0;
    m_if.tready = 1'b1;

    // Bad-frame counter saturates at all-ones.
    for (int i = 0; i < 4; i++) send_frame(20 + i, 1, 1'b1, 1'b0, 8'hFF);
    chk("t7_bad_sat", 64'(bad_cnt), 64'd3);
    chk("t7_used", 64'(used), 64'd0);
    repeat (3) step();
    chk("t7_no_output", 64'(m_if.tvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
